data_mem_responder: RTL and testbench

- Data-memory responder for the MEM stage of the 5-stage MIPS pipeline. The datapath's memRead/memWrite are the initiator side; this block is the memory end of that interface.
- Models a multi-cycle memory. It holds the pipeline with a stall output until each access completes, then returns read data or commits the write.
- Sits between the EX/MEM pipeline register outputs and the MEM/WB register inputs. Its stall output ORs into the pipeline's global freeze.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/data_mem_responder_dm_array.sv | 60 ++++++
 rtl/data_mem_responder.sv | 174 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline memory-stage blocks.
// Contents:
//   state_t    - responder FSM states (IDLE, WAIT, DONE)
//   WORD_W     - data word width
//   CNT_W      - latency counter width, covers LATENCY values up to 15
//   idx_width  - word-index width for a given storage depth
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  // Index width for a power-of-two word count; never narrower than one bit.
  function automatic int idx_width(input int depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/data_mem_responder_dm_array.sv
// dm_array: single-port word storage for the data-memory responder.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset, clears every word and the read register
//   we     in   write enable, stores wdata at idx on the clock edge
//   re     in   read enable, loads mem[idx] into the read register
//   rclr   in   loads zero into the read register (misaligned read result)
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data, held until the next re or rclr
module dm_array
  import pipeline_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              rclr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_d;
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rclr) begin
      rdata_d = '0;
    end else if (re) begin
      rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory at the MEM stage of the 5-stage
// MIPS pipeline. Stalls the pipeline for LATENCY cycles per access, then
// completes the access with a one-cycle DONE.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   mem_read    in   read request, held until completion
//   mem_write   in   write request, held until completion (wins over read)
//   addr        in   byte address
//   write_data  in   store data
//   read_data   out  load data, valid in DONE and held afterwards
//   mem_stall   out  pipeline freeze
//   mem_done    out  one-cycle completion pulse
//   mem_err     out  one-cycle pulse with mem_done on misaligned or read+write access
module data_mem_responder
  import pipeline_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              mem_stall,
  output logic              mem_done,
  output logic              mem_err
);

  localparam int             IDX_W  = idx_width(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              mis_q, mis_d;
  logic              both_q, both_d;
  logic              err_q, err_d;

  logic              req;
  logic              fire;
  logic [IDX_W-1:0]  cur_idx;
  logic [WORD_W-1:0] cur_wdata;
  logic              cur_wr;
  logic              cur_mis;
  logic              cur_both;
  logic              arr_we;
  logic              arr_re;
  logic              arr_rclr;
  logic              unused_addr_bits;

  assign req              = mem_read | mem_write;
  assign unused_addr_bits = ^addr[WORD_W-1:IDX_W+2];

  // In IDLE the access can complete on the acceptance edge (LATENCY==1),
  // so the live inputs are used there; afterwards only captured values.
  always_comb begin
    if (state_q == IDLE) begin
      cur_idx   = addr[2 +: IDX_W];
      cur_wdata = write_data;
      cur_wr    = mem_write;
      cur_mis   = |addr[1:0];
      cur_both  = mem_read & mem_write;
    end else begin
      cur_idx   = idx_q;
      cur_wdata = wdata_q;
      cur_wr    = wr_q;
      cur_mis   = mis_q;
      cur_both  = both_q;
    end
  end

  // The acceptance cycle is the first stall cycle; cnt_q holds the stall
  // cycles still owed including the current WAIT cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    both_d  = both_q;
    err_d   = 1'b0;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = addr[2 +: IDX_W];
          wdata_d = write_data;
          wr_d    = mem_write;
          mis_d   = |addr[1:0];
          both_d  = mem_read & mem_write;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            fire = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          fire = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (fire) begin
      state_d = DONE;
      err_d   = cur_mis | cur_both;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      both_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
      both_q  <= both_d;
      err_q   <= err_d;
    end
  end

  // Misaligned accesses never touch storage; a misaligned read returns zero.
  assign arr_we   = fire & cur_wr & ~cur_mis;
  assign arr_re   = fire & ~cur_wr & ~cur_mis;
  assign arr_rclr = fire & ~cur_wr & cur_mis;

  dm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .rclr  (arr_rclr),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .rdata (read_data)
  );

  // Stall is gated by rst so a held request cannot freeze the pipe in reset.
  assign mem_stall = ~rst & (((state_q == IDLE) & req) | (state_q == WAIT));
  assign mem_done  = (state_q == DONE);
  assign mem_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed scenarios plus randomized
// accesses checked against a word-array reference model.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_rd;

  data_mem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .mem_stall  (mem_stall),
    .mem_done   (mem_done),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    model_rd = '0;
  endtask

  // Memory semantics: word index is addr[9:2]; misaligned writes are dropped,
  // misaligned reads return zero; write wins when both requests are high.
  task automatic model_apply(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (w) begin
      if (a[1:0] == 2'b00) model_mem[a[9:2]] = d;
    end else if (r) begin
      model_rd = (a[1:0] != 2'b00) ? 32'h0 : model_mem[a[9:2]];
    end
  endtask

  // Drives one access starting at a negedge and observes it cycle by cycle.
  // abort_at > 0 drops the request in that cycle. done_cyc==0 means no DONE seen.
  task automatic run_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int abort_at, output int stalls, output int done_cyc,
                            output logic err_v, output logic [31:0] rd_v,
                            output logic done_next, output logic err_next);
    stalls = 0; done_cyc = 0; err_v = 1'b0; rd_v = '0; done_next = 1'b0; err_next = 1'b0;
    @(negedge clk);
    mem_read = r; mem_write = w; addr = a; write_data = d;
    for (int c = 1; c <= LAT + 6; c++) begin
      if (c > 1) begin
        addr = $urandom;
        write_data = $urandom;
      end
      if (c == abort_at) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
      #1;
      if (mem_stall) stalls++;
      if (mem_done) begin
        done_cyc = c;
        err_v = mem_err;
        rd_v = read_data;
        break;
      end
      @(negedge clk);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    #1;
    done_next = mem_done;
    err_next = mem_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10; write_data = '0;
    #12;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall); end
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
    checks++;
    if ({mem_done, mem_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b expected 00", {mem_done, mem_err}); end
    @(negedge clk);
    mem_read = 1'b0;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_write_read();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, st, dc, e, rv, dn, en);
    model_apply(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    checks++;
    if (st != LAT) begin errors++; $display("FAIL wr_stall_cycles: got %0d expected %0d", st, LAT); end
    checks++;
    if (dc != LAT + 1) begin errors++; $display("FAIL wr_done_cycle: got %0d expected %0d", dc, LAT + 1); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", e); end
    checks++;
    if (dn !== 1'b0) begin errors++; $display("FAIL wr_done_pulse_width: got %b expected 0", dn); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h10, 32'h0);
    checks++;
    if (st != LAT) begin errors++; $display("FAIL rd_stall_cycles: got %0d expected %0d", st, LAT); end
    checks++;
    if (dc != LAT + 1) begin errors++; $display("FAIL rd_done_cycle: got %0d expected %0d", dc, LAT + 1); end
    checks++;
    if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rv); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", e); end
    checks++;
    if (read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_held: got %h expected deadbeef", read_data); end
  endtask

  task automatic test_wrap();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    run_access(1'b0, 1'b1, 32'h400, 32'h12345678, 0, st, dc, e, rv, dn, en);
    model_apply(1'b0, 1'b1, 32'h400, 32'h12345678);
    run_access(1'b1, 1'b0, 32'h000, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h000, 32'h0);
    checks++;
    if (rv !== 32'h12345678) begin errors++; $display("FAIL wrap_data: got %h expected 12345678", rv); end
  endtask

  task automatic test_misaligned();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    run_access(1'b1, 1'b0, 32'h13, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h13, 32'h0);
    checks++;
    if (st != LAT || dc != LAT + 1) begin errors++; $display("FAIL mis_timing: got stall %0d done %0d expected %0d %0d", st, dc, LAT, LAT + 1); end
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL mis_data: got %h expected 0", rv); end
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", e); end
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL mis_err_pulse_width: got %b expected 0", en); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h10, 32'h0);
    checks++;
    if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_storage_kept: got %h expected deadbeef", rv); end
  endtask

  task automatic test_abort();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    run_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 2, st, dc, e, rv, dn, en);
    checks++;
    if (dc != 0) begin errors++; $display("FAIL abort_no_done: got done cycle %0d expected none", dc); end
    checks++;
    if (read_data !== model_rd) begin errors++; $display("FAIL abort_read_data_kept: got %h expected %h", read_data, model_rd); end
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h20, 32'h0);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL abort_no_write: got %h expected 0", rv); end
  endtask

  task automatic test_both();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    run_access(1'b1, 1'b1, 32'h30, 32'h0000ABCD, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b1, 32'h30, 32'h0000ABCD);
    checks++;
    if (e !== 1'b1 || dc != LAT + 1) begin errors++; $display("FAIL both_err: got err %b done %0d expected 1 %0d", e, dc, LAT + 1); end
    run_access(1'b1, 1'b0, 32'h30, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h30, 32'h0);
    checks++;
    if (rv !== 32'h0000ABCD || e !== 1'b0) begin errors++; $display("FAIL both_write_committed: got %h err %b expected 0000abcd err 0", rv, e); end
  endtask

  task automatic test_async_reset();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h08; write_data = 32'h55AA55AA;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL arst_stall: got %b expected 0", mem_stall); end
    checks++;
    if (read_data !== 32'h0 || mem_done !== 1'b0) begin errors++; $display("FAIL arst_outputs: got data %h done %b expected 0 0", read_data, mem_done); end
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run_access(1'b1, 1'b0, 32'h08, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h08, 32'h0);
    checks++;
    if (rv !== 32'h0 || dc != LAT + 1) begin errors++; $display("FAIL arst_write_dropped: got %h done %0d expected 0 %0d", rv, dc, LAT + 1); end
    run_access(1'b1, 1'b0, 32'h30, 32'h0, 0, st, dc, e, rv, dn, en);
    model_apply(1'b1, 1'b0, 32'h30, 32'h0);
    checks++;
    if (rv !== 32'h0) begin errors++; $display("FAIL arst_storage_cleared: got %h expected 0", rv); end
  endtask

  task automatic test_random();
    int st, dc; logic e, dn, en; logic [31:0] rv;
    for (int n = 0; n < 80; n++) begin
      int op, ab;
      logic r, w, mis;
      logic [31:0] a, d;
      op = $urandom_range(0, 9);
      r = (op < 4) || (op == 8);
      w = (op >= 4);
      a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      d = $urandom;
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(2, LAT) : 0;
      mis = (a[1:0] != 2'b00);
      run_access(r, w, a, d, ab, st, dc, e, rv, dn, en);
      if (ab != 0) begin
        checks++;
        if (dc != 0 || st != ab) begin errors++; $display("FAIL rnd_abort[%0d]: got done %0d stall %0d expected 0 %0d", n, dc, st, ab); end
        checks++;
        if (read_data !== model_rd) begin errors++; $display("FAIL rnd_abort_data[%0d]: got %h expected %h", n, read_data, model_rd); end
      end else begin
        model_apply(r, w, a, d);
        checks++;
        if (st != LAT || dc != LAT + 1) begin errors++; $display("FAIL rnd_timing[%0d]: got stall %0d done %0d expected %0d %0d", n, st, dc, LAT, LAT + 1); end
        checks++;
        if (e !== (mis | (r & w))) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", n, e, mis | (r & w)); end
        checks++;
        if (rv !== model_rd) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h addr %h", n, rv, model_rd, a); end
        checks++;
        if (dn !== 1'b0 || en !== 1'b0 || read_data !== model_rd) begin
          errors++; $display("FAIL rnd_after_done[%0d]: got done %b err %b data %h expected 0 0 %h", n, dn, en, read_data, model_rd);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_misaligned();
    test_abort();
    test_both();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
